// File: rtl/spi_apb_master.sv
// SPI mode-0 peripheral that turns 24-bit host command frames into APB reads and writes.
// SPI pins are oversampled and synchronised into PCLK; there is no second clock domain.
module spi_apb_master #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        spi_cs_l,
  input  logic        spi_clk,
  input  logic        spi_data,
  output logic        slave_data,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy,
  output logic        rd_late,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} apb_state_e;

  localparam logic [4:0] CMD_LAST   = 5'd7;   // counter value before the 8th rising edge
  localparam logic [4:0] TX_FIRST   = 5'd8;
  localparam logic [4:0] FRAME_LAST = 5'd23;  // counter value before the 24th rising edge
  localparam logic [4:0] FRAME_BITS = 5'd24;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d;
  logic                   w_sclk, w_cs_n, w_mosi, w_rise, w_fall;

  apb_state_e  r_state, w_next_state;
  logic [4:0]  r_bit_cnt;
  logic [14:0] r_rx;
  logic [15:0] w_rx_next;
  logic [15:0] r_tx;
  logic        r_miso, r_frame_ok, r_cmd_rw, r_rd_pend, r_tx_lock;
  logic        r_rd_late, r_overrun;
  logic [31:0] r_paddr, r_pwdata;
  logic        r_pwrite;
  logic        w_busy, w_cmd_edge, w_accept, w_rd_launch, w_wr_launch, w_launch;
  logic        w_apb_done, w_late, w_tx_win;
  logic        w_unused_prdata;

  // Chip select resets to the inactive level so no phantom frame starts after reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the previous-cycle values.
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_l};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_data};
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_rx_next = {r_rx, w_mosi};

  assign w_busy      = (r_state != S_IDLE);
  assign w_cmd_edge  = ~w_cs_n & w_rise & (r_bit_cnt == CMD_LAST);
  assign w_accept    = w_cmd_edge & ~w_busy;
  assign w_rd_launch = w_accept & ~w_rx_next[7];
  assign w_wr_launch = ~w_cs_n & w_rise & (r_bit_cnt == FRAME_LAST) & r_frame_ok & r_cmd_rw;
  assign w_launch    = w_rd_launch | w_wr_launch;
  assign w_apb_done  = (r_state == S_ACCESS) & PREADY;
  assign w_late      = r_frame_ok & ~r_cmd_rw & r_rd_pend;
  assign w_tx_win    = (r_bit_cnt >= TX_FIRST) && (r_bit_cnt <= FRAME_LAST);

  assign w_unused_prdata = ^PRDATA[31:16];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the value held (no latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_next_state = S_SETUP;
      S_SETUP:  w_next_state = S_ACCESS;
      S_ACCESS: if (PREADY) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    busy    = 1'b0;
    case (r_state)
      S_SETUP:  begin PSEL = 1'b1; busy = 1'b1; end
      S_ACCESS: begin PSEL = 1'b1; PENABLE = 1'b1; busy = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_frame_ok <= 1'b0;
      r_cmd_rw   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_tx_lock  <= 1'b0;
      r_rd_late  <= 1'b0;
      r_overrun  <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
    end else begin
      r_rd_late <= 1'b0;
      r_overrun <= w_cmd_edge & w_busy;
      if (w_cs_n) begin
        r_bit_cnt  <= '0;
        r_rx       <= '0;
        r_tx       <= '0;
        r_miso     <= 1'b0;
        r_frame_ok <= 1'b0;
        r_cmd_rw   <= 1'b0;
        r_rd_pend  <= 1'b0;
        r_tx_lock  <= 1'b0;
      end else begin
        if (w_rise && (r_bit_cnt != FRAME_BITS)) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          r_rx      <= w_rx_next[14:0];
        end
        if (w_accept) begin
          r_frame_ok <= 1'b1;
          r_cmd_rw   <= w_rx_next[7];
          r_paddr    <= ADDR_BASE + {23'd0, w_rx_next[6:0], 2'b00};
          r_pwrite   <= w_rx_next[7];
        end
        if (w_wr_launch) r_pwdata <= {16'd0, w_rx_next};
        if (w_rd_launch)     r_rd_pend <= 1'b1;
        else if (w_apb_done) r_rd_pend <= 1'b0;
        if (w_apb_done && r_rd_pend && !r_tx_lock) r_tx <= PRDATA[15:0];
        // A read still pending at the first data bit is replaced by all-ones for this frame,
        // and the lock keeps its later completion from corrupting the word mid-shift.
        if (w_fall) begin
          if (w_tx_win && (r_bit_cnt == TX_FIRST) && w_late) begin
            r_miso    <= 1'b1;
            r_tx      <= 16'hFFFE;
            r_tx_lock <= 1'b1;
            r_rd_late <= 1'b1;
          end else if (w_tx_win) begin
            r_miso <= r_tx[15];
            r_tx   <= {r_tx[14:0], 1'b0};
          end else begin
            r_miso <= 1'b0;
          end
        end
      end
    end
  end

  assign slave_data = r_miso;
  assign PADDR      = r_paddr;
  assign PWRITE     = r_pwrite;
  assign PWDATA     = r_pwdata;
  assign rd_late    = r_rd_late;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_apb_master.sv
// Directed bench for spi_apb_master: an SPI host task drives frames while a cycle monitor
// answers APB with a programmable PREADY delay and records transfers and protocol errors.
module tb_spi_apb_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        spi_cs_l = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_data = 1'b0;
  logic        slave_data;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        busy, rd_late, overrun;

  spi_apb_master #(.ADDR_BASE(BASE), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .spi_cs_l(spi_cs_l), .spi_clk(spi_clk),
    .spi_data(spi_data), .slave_data(slave_data), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .busy(busy), .rd_late(rd_late), .overrun(overrun)
  );

  initial forever #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail = 0;

  int ready_delay = 0;
  int acc_k = 0;
  int fall_cnt = 0;
  int setup_cyc, access_cyc, busy_cyc, txn_cnt, late_cyc, late_at, over_cyc, miso_hi, proto_err;
  logic [31:0] t_addr, t_wdata;
  logic        t_write;
  logic        p_psel = 1'b0, p_pen = 1'b0, p_done = 1'b0, p_write = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [23:0] rx, rx2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic clear_mon();
    setup_cyc = 0; access_cyc = 0; busy_cyc = 0; txn_cnt = 0; late_cyc = 0;
    late_at = -1; over_cyc = 0; miso_hi = 0; proto_err = 0;
    t_addr = '0; t_wdata = '0; t_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      wait_cyc(1);
      n++;
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Mode-0 host: data set while SCLK is low, MISO sampled just before each rising edge.
  task automatic spi_frame(input logic [23:0] frame, input int nbits, input int hp,
                           output logic [23:0] rx_o);
    rx_o = '0;
    fall_cnt = 0;
    spi_cs_l = 1'b0;
    wait_cyc(hp);
    for (int i = 0; i < nbits; i++) begin
      spi_data = frame[23-i];
      wait_cyc(hp);
      rx_o = {rx_o[22:0], slave_data};
      spi_clk = 1'b1;
      wait_cyc(hp);
      spi_clk = 1'b0;
      fall_cnt++;
    end
    wait_cyc(hp);
    spi_cs_l = 1'b1;
    spi_data = 1'b0;
    wait_cyc(hp);
  endtask

  // APB responder and monitor, evaluated away from the active edge.
  initial forever begin
    @(negedge PCLK);
    if (!PRESETn) begin
      p_psel = 1'b0; p_pen = 1'b0; p_done = 1'b0; acc_k = 0;
      PREADY = (ready_delay == 0);
    end else begin
      if (PSEL && PENABLE) begin
        PREADY = (acc_k >= ready_delay);
        acc_k++;
      end else begin
        acc_k = 0;
        PREADY = (ready_delay == 0);
      end
      if (busy !== PSEL) proto_err++;
      if (PENABLE && !PSEL) proto_err++;
      if (p_psel && !p_pen && !(PSEL && PENABLE)) proto_err++;
      if (p_psel && p_pen && !p_done && !(PSEL && PENABLE)) proto_err++;
      if (p_done && PSEL) proto_err++;
      if (p_psel && PSEL && !p_done &&
          (PADDR !== p_addr || PWRITE !== p_write || PWDATA !== p_wdata)) proto_err++;
      if (PSEL && !PENABLE) setup_cyc++;
      if (PSEL && PENABLE) access_cyc++;
      if (busy) busy_cyc++;
      if (rd_late) begin late_cyc++; late_at = fall_cnt; end
      if (overrun) over_cyc++;
      if (slave_data) miso_hi++;
      p_done = PSEL && PENABLE && PREADY;
      if (p_done) begin
        txn_cnt++;
        t_addr = PADDR; t_wdata = PWDATA; t_write = PWRITE;
      end
      p_psel = PSEL; p_pen = PENABLE; p_addr = PADDR; p_write = PWRITE; p_wdata = PWDATA;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    wait_cyc(3);
    check("reset ctrl", {25'd0, PSEL, PENABLE, busy, PWRITE, slave_data, rd_late, overrun}, 32'd0);
    check("reset paddr", PADDR, 32'd0);
    check("reset pwdata", PWDATA, 32'd0);
    PRESETn = 1'b1;
    wait_cyc(4);

    // Write A=5, data 0x1234, zero-wait APB
    clear_mon();
    spi_frame(24'h85_1234, 24, 8, rx);
    wait_idle("wr1", 50);
    check("wr1 txn count", txn_cnt, 1);
    check("wr1 paddr", t_addr, BASE + 32'h14);
    check("wr1 pwrite", {31'd0, t_write}, 1);
    check("wr1 pwdata", t_wdata, 32'h0000_1234);
    check("wr1 setup cycles", setup_cyc, 1);
    check("wr1 access cycles", access_cyc, 1);
    check("wr1 busy cycles", busy_cyc, 2);
    check("wr1 miso high cycles", miso_hi, 0);
    check("wr1 protocol", proto_err, 0);

    // Read A=3, zero-wait: upper PRDATA half must not leak
    clear_mon();
    PRDATA = 32'hDEAD_BEEF;
    spi_frame(24'h03_0000, 24, 8, rx);
    wait_idle("rd1", 50);
    check("rd1 host data", {8'd0, rx}, 32'h0000_BEEF);
    check("rd1 rd_late", late_cyc, 0);
    check("rd1 txn count", txn_cnt, 1);
    check("rd1 paddr", t_addr, BASE + 32'h0C);
    check("rd1 pwrite", {31'd0, t_write}, 0);
    check("rd1 protocol", proto_err, 0);

    // Read A=3 with PREADY low for 200 cycles: late, host sees all ones
    clear_mon();
    ready_delay = 200;
    PRDATA = 32'h0000_1357;
    spi_frame(24'h03_0000, 24, 8, rx);
    wait_idle("rd2", 400);
    check("rd2 rd_late cycles", late_cyc, 1);
    check("rd2 rd_late at fall", late_at, 8);
    check("rd2 host data", {8'd0, rx}, 32'h0000_FFFF);
    check("rd2 txn count", txn_cnt, 1);
    check("rd2 paddr", t_addr, BASE + 32'h0C);
    check("rd2 access cycles", access_cyc, 201);
    check("rd2 protocol", proto_err, 0);

    // Write aborted after 20 bits, then a full write to A=1
    clear_mon();
    ready_delay = 0;
    spi_frame(24'h8F_5555, 20, 8, rx);
    wait_cyc(20);
    check("abort setup cycles", setup_cyc, 0);
    spi_frame(24'h81_00AA, 24, 8, rx);
    wait_idle("wr2", 50);
    check("wr2 txn count", txn_cnt, 1);
    check("wr2 paddr", t_addr, BASE + 32'h04);
    check("wr2 pwdata", t_wdata, 32'h0000_00AA);
    check("wr2 pwrite", {31'd0, t_write}, 1);

    // Slow write, then a read command decoded while busy
    clear_mon();
    ready_delay = 100;
    spi_frame(24'h82_CAFE, 24, 8, rx);
    check("ovr first in flight", {31'd0, busy}, 1);
    spi_frame(24'h07_0000, 24, 4, rx2);
    wait_idle("ovr", 200);
    wait_cyc(20);
    check("ovr pulse cycles", over_cyc, 1);
    check("ovr txn count", txn_cnt, 1);
    check("ovr setup cycles", setup_cyc, 1);
    check("ovr paddr", t_addr, BASE + 32'h08);
    check("ovr pwdata", t_wdata, 32'h0000_CAFE);
    check("ovr access cycles", access_cyc, 101);
    check("ovr dropped host data", {8'd0, rx2}, 32'd0);
    check("ovr rd_late", late_cyc, 0);
    check("ovr protocol", proto_err, 0);

    // Reset during ACCESS, then a fresh read
    clear_mon();
    ready_delay = 200;
    spi_frame(24'h84_0F0F, 24, 8, rx);
    begin
      int n = 0;
      while (!(PSEL && PENABLE) && n < 50) begin
        wait_cyc(1);
        n++;
      end
    end
    check("rst in access", {30'd0, PSEL, PENABLE}, 32'd3);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst async clear", {29'd0, PSEL, PENABLE, busy}, 32'd0);
    wait_cyc(2);
    ready_delay = 0;
    PRESETn = 1'b1;
    wait_cyc(4);
    clear_mon();
    PRDATA = 32'h0000_A5C3;
    spi_frame(24'h09_0000, 24, 8, rx);
    wait_idle("rd3", 50);
    check("rd3 host data", {8'd0, rx}, 32'h0000_A5C3);
    check("rd3 txn count", txn_cnt, 1);
    check("rd3 paddr", t_addr, BASE + 32'h24);
    check("rd3 rd_late", late_cyc, 0);
    check("rd3 protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
